// File: rtl/result_bcd_display_pkg.sv
// ---------------------------------------------------------------------------
// result_bcd_display_pkg
// Shared proc4 definitions for the result display path:
//   - FSM state encoding for the BCD converter (IDLE, CONV)
//   - 7-segment patterns for 0-9, minus and blank, active-high {g,f,e,d,c,b,a}
//   - digit indices for the multiplexed sign/tens/units display
// ---------------------------------------------------------------------------
package result_bcd_display_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    // Five shifts are needed for a 5-bit magnitude; the count runs 0..4.
    localparam logic [2:0] SHIFT_LAST = 3'd4;

    localparam logic [1:0] DIGIT_UNITS = 2'd0;
    localparam logic [1:0] DIGIT_TENS  = 2'd1;
    localparam logic [1:0] DIGIT_SIGN  = 2'd2;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_MINUS = 7'b1000000;

    // Active-high segment pattern for a decimal digit; non-decimal codes blank.
    function automatic logic [6:0] seg7_pattern(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'b0111111;
            4'd1:    pattern = 7'b0000110;
            4'd2:    pattern = 7'b1011011;
            4'd3:    pattern = 7'b1001111;
            4'd4:    pattern = 7'b1100110;
            4'd5:    pattern = 7'b1101101;
            4'd6:    pattern = 7'b1111101;
            4'd7:    pattern = 7'b0000111;
            4'd8:    pattern = 7'b1111111;
            4'd9:    pattern = 7'b1101111;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/result_bcd_display_bcd_to_seg7.sv
// ---------------------------------------------------------------------------
// bcd_to_seg7
// Combinational BCD digit to active-high 7-segment pattern decoder.
// Ports:
//   digit    in   4  BCD digit 0..9
//   blank    in   1  force all segments off
//   pattern  out  7  segments {g,f,e,d,c,b,a}, active-high
// ---------------------------------------------------------------------------
module bcd_to_seg7
    import result_bcd_display_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = seg7_pattern(digit);
        if (blank) begin
            pattern = SEG_BLANK;
        end
    end

endmodule

// File: rtl/result_bcd_display.sv
// ---------------------------------------------------------------------------
// result_bcd_display
// Captures a sign-magnitude ALU result, converts the 5-bit magnitude to two
// BCD digits by sequential double-dabble (one shift per clock) and drives a
// 3-digit multiplexed 7-segment display (sign, tens, units).
// Ports:
//   clk        in   1  system clock, posedge
//   rst        in   1  synchronous reset, active-high
//   in_valid   in   1  result present on in_sign/in_mag
//   in_ready   out  1  idle; result accepted when in_valid & in_ready
//   in_sign    in   1  result sign (1 = negative)
//   in_mag     in   5  result magnitude 0..31
//   done       out  1  one-cycle pulse: new bcd/neg values valid
//   neg        out  1  registered display sign
//   bcd_tens   out  4  registered tens digit
//   bcd_units  out  4  registered units digit
//   seg        out  7  segments {g,f,e,d,c,b,a} of the active digit
//   an         out  3  one-hot digit enables: [0]=units [1]=tens [2]=sign
// ---------------------------------------------------------------------------
module result_bcd_display
    import result_bcd_display_pkg::*;
#(
    parameter int REFRESH_BITS   = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit BLANK_LZ       = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_sign,
    input  logic [4:0] in_mag,
    output logic       done,
    output logic       neg,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_units,
    output logic [6:0] seg,
    output logic [2:0] an
);

    state_t                  state;
    state_t                  state_nxt;
    logic                    accept;
    logic                    last_shift;

    logic [4:0]              mag_sr;
    logic [7:0]              scratch;
    logic [7:0]              scratch_adj;
    logic [12:0]             shifted;
    logic [2:0]              shift_cnt;
    logic                    sign_l;

    logic [REFRESH_BITS-1:0] refresh_cnt;
    logic [1:0]              digit_idx;
    logic [3:0]              dec_digit;
    logic                    dec_blank;
    logic [6:0]              dec_pattern;
    logic [6:0]              seg_hi;
    logic [2:0]              an_hi;

    assign accept     = in_valid && (state == IDLE);
    assign last_shift = (state == CONV) && (shift_cnt == SHIFT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = CONV;
                end
            end
            CONV: begin
                if (last_shift) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Double-dabble step: correct each BCD nibble before it is doubled, then
    // shift the whole {bcd, magnitude} word left by one.
    always_comb begin
        scratch_adj = scratch;
        if (scratch[3:0] >= 4'd5) begin
            scratch_adj[3:0] = scratch[3:0] + 4'd3;
        end
        if (scratch[7:4] >= 4'd5) begin
            scratch_adj[7:4] = scratch[7:4] + 4'd3;
        end
        shifted = {scratch_adj, mag_sr} << 1;
    end

    // The visible bcd/neg registers only change on the final shift, so the
    // display never shows a half-converted value.
    always_ff @(posedge clk) begin
        if (rst) begin
            mag_sr    <= '0;
            scratch   <= '0;
            shift_cnt <= '0;
            sign_l    <= 1'b0;
            done      <= 1'b0;
            neg       <= 1'b0;
            bcd_tens  <= '0;
            bcd_units <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                mag_sr    <= in_mag;
                scratch   <= '0;
                shift_cnt <= '0;
                // Negative zero is shown without a minus sign.
                sign_l    <= in_sign && (in_mag != 5'd0);
            end else if (state == CONV) begin
                {scratch, mag_sr} <= shifted;
                shift_cnt         <= shift_cnt + 3'd1;
                if (last_shift) begin
                    bcd_tens  <= shifted[12:9];
                    bcd_units <= shifted[8:5];
                    neg       <= sign_l;
                    done      <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            digit_idx   <= DIGIT_UNITS;
        end else begin
            refresh_cnt <= refresh_cnt + REFRESH_BITS'(1);
            if (&refresh_cnt) begin
                digit_idx <= (digit_idx == DIGIT_SIGN) ? DIGIT_UNITS : digit_idx + 2'd1;
            end
        end
    end

    always_comb begin
        dec_digit = bcd_units;
        dec_blank = 1'b0;
        an_hi     = 3'b001;
        case (digit_idx)
            DIGIT_TENS: begin
                dec_digit = bcd_tens;
                dec_blank = BLANK_LZ && (bcd_tens == 4'd0);
                an_hi     = 3'b010;
            end
            DIGIT_SIGN: begin
                an_hi     = 3'b100;
            end
            default: begin
                dec_digit = bcd_units;
                an_hi     = 3'b001;
            end
        endcase
    end

    bcd_to_seg7 u_dec (
        .digit   (dec_digit),
        .blank   (dec_blank),
        .pattern (dec_pattern)
    );

    always_comb begin
        seg_hi = dec_pattern;
        if (digit_idx == DIGIT_SIGN) begin
            seg_hi = neg ? SEG_MINUS : SEG_BLANK;
        end
    end

    // Polarity is applied only here; everything upstream is active-high.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= {7{SEG_ACTIVE_LOW}} ^ seg7_pattern(4'd0);
            an  <= {3{SEG_ACTIVE_LOW}} ^ 3'b001;
        end else begin
            seg <= {7{SEG_ACTIVE_LOW}} ^ seg_hi;
            an  <= {3{SEG_ACTIVE_LOW}} ^ an_hi;
        end
    end

endmodule
